// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - kernel/image loader and shared-MAC sliding-window sequencer
module conv_window_sequencer #(
    parameter int DATA_W  = 6,
    parameter int IMG_DIM = 6,
    parameter int K       = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    input  logic                                  wgt_valid,
    output logic                                  wgt_ready,
    input  logic [DATA_W-1:0]                     wgt_data,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    input  logic [DATA_W-1:0]                     pix_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [2*DATA_W+$clog2(K*K)-1:0]       out_data,
    output logic [$clog2(IMG_DIM-K+1)-1:0]        out_row,
    output logic [$clog2(IMG_DIM-K+1)-1:0]        out_col,
    output logic                                  out_last
);

    localparam int OUT_DIM = IMG_DIM - K + 1;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int ACC_W   = PROD_W + $clog2(K * K);
    localparam int RC_W    = $clog2(OUT_DIM);
    localparam int NW      = K * K;
    localparam int NP      = IMG_DIM * IMG_DIM;
    localparam int WA_W    = $clog2(NW);
    localparam int PA_W    = $clog2(NP);
    localparam int KI_W    = $clog2(K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_P,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WA_W-1:0]   wcnt_q, wcnt_d;
    logic [PA_W-1:0]   pcnt_q, pcnt_d;
    logic [WA_W-1:0]   tap_q, tap_d;
    logic [KI_W-1:0]   kr_q, kr_d;
    logic [KI_W-1:0]   kc_q, kc_d;
    logic [RC_W-1:0]   wr_q, wr_d;
    logic [RC_W-1:0]   wc_q, wc_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic [DATA_W-1:0] w_mem [NW];
    logic [DATA_W-1:0] p_mem [NP];

    logic [PA_W-1:0]   pix_addr;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] p_rd;
    logic [PROD_W-1:0] prod;
    logic              last_win;

    // Shared MAC datapath: current tap's pixel inside the current window times its weight.
    always_comb begin
        pix_addr = PA_W'((int'(wr_q) + int'(kr_q)) * IMG_DIM + int'(wc_q) + int'(kc_q));
        w_rd     = w_mem[tap_q];
        p_rd     = p_mem[pix_addr];
        prod     = {{DATA_W{1'b0}}, w_rd} * {{DATA_W{1'b0}}, p_rd};
        last_win = (wr_q == RC_W'(OUT_DIM - 1)) && (wc_q == RC_W'(OUT_DIM - 1));
    end

    assign out_data = acc_q;
    assign out_row  = wr_q;
    assign out_col  = wc_q;

    // Next-state, counter and handshake-output logic for the load/MAC/emit sequence.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        pcnt_d    = pcnt_q;
        tap_d     = tap_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        wr_d      = wr_q;
        wc_d      = wc_q;
        acc_d     = acc_q;
        busy      = 1'b0;
        done      = 1'b0;
        wgt_ready = 1'b0;
        pix_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_W;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end
            end
            S_LOAD_W: begin
                busy      = 1'b1;
                wgt_ready = 1'b1;
                if (wgt_valid) begin
                    if (wcnt_q == WA_W'(NW - 1)) begin
                        state_d = S_LOAD_P;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + WA_W'(1);
                    end
                end
            end
            S_LOAD_P: begin
                busy      = 1'b1;
                pix_ready = 1'b1;
                if (pix_valid) begin
                    if (pcnt_q == PA_W'(NP - 1)) begin
                        state_d = S_MAC;
                        pcnt_d  = '0;
                        tap_d   = '0;
                        kr_d    = '0;
                        kc_d    = '0;
                        wr_d    = '0;
                        wc_d    = '0;
                        acc_d   = '0;
                    end else begin
                        pcnt_d = pcnt_q + PA_W'(1);
                    end
                end
            end
            S_MAC: begin
                busy  = 1'b1;
                acc_d = acc_q + {{(ACC_W - PROD_W){1'b0}}, prod};
                if (tap_q == WA_W'(NW - 1)) begin
                    state_d = S_EMIT;
                    tap_d   = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                end else begin
                    tap_d = tap_q + WA_W'(1);
                    if (kc_q == KI_W'(K - 1)) begin
                        kc_d = '0;
                        kr_d = kr_q + KI_W'(1);
                    end else begin
                        kc_d = kc_q + KI_W'(1);
                    end
                end
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = last_win;
                if (out_ready) begin
                    if (last_win) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MAC;
                        acc_d   = '0;
                        if (wc_q == RC_W'(OUT_DIM - 1)) begin
                            wc_d = '0;
                            wr_d = wr_q + RC_W'(1);
                        end else begin
                            wc_d = wc_q + RC_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            pcnt_q  <= '0;
            tap_q   <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pcnt_q  <= pcnt_d;
            tap_q   <= tap_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            wr_q    <= wr_d;
            wc_q    <= wc_d;
            acc_q   <= acc_d;
        end
    end

    // Kernel and image buffers; not cleared by reset because every run rewrites them first.
    always_ff @(posedge clk) begin
        if (rst_n && wgt_ready && wgt_valid) begin
            w_mem[wcnt_q] <= wgt_data;
        end
        if (rst_n && pix_ready && pix_valid) begin
            p_mem[pcnt_q] <= pix_data;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench for conv_window_sequencer
module tb_conv_window_sequencer;

    localparam int DATA_W  = 6;
    localparam int IMG_DIM = 6;
    localparam int K       = 3;
    localparam int OUT_DIM = 4;
    localparam int ACC_W   = 16;
    localparam int RC_W    = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              busy;
    logic              done;
    logic              wgt_valid;
    logic              wgt_ready;
    logic [DATA_W-1:0] wgt_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [RC_W-1:0]   out_row;
    logic [RC_W-1:0]   out_col;
    logic              out_last;

    conv_window_sequencer #(.DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wgt_valid (wgt_valid),
        .wgt_ready (wgt_ready),
        .wgt_data  (wgt_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int row;
        int col;
        int last;
        int gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   out_cnt  = 0;
    int   last_xfer = 0;
    bit   hold_ok  = 0;
    int   hold_data, hold_row, hold_col, hold_last;

    logic [DATA_W-1:0] w_vec [9];
    logic [DATA_W-1:0] p_vec [36];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every accepted result and checks stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) chk("ready_valid_exclusive", int'(wgt_ready) + int'(pix_ready) + int'(out_valid), int'(out_valid || wgt_ready || pix_ready));
            if (out_valid && !out_ready) begin
                if (hold_ok) begin
                    chk("stall_data", int'(out_data), hold_data);
                    chk("stall_row", int'(out_row), hold_row);
                    chk("stall_col", int'(out_col), hold_col);
                    chk("stall_last", int'(out_last), hold_last);
                end
                hold_ok   = 1;
                hold_data = int'(out_data);
                hold_row  = int'(out_row);
                hold_col  = int'(out_col);
                hold_last = int'(out_last);
            end else begin
                hold_ok = 0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), e.data);
                    chk("out_row", int'(out_row), e.row);
                    chk("out_col", int'(out_col), e.col);
                    chk("out_last", int'(out_last), e.last);
                    if (e.gap != 0) chk("out_spacing", cyc - last_xfer, e.gap);
                end
                last_xfer = cyc;
                out_cnt++;
            end
        end else begin
            hold_ok = 0;
        end
    end

    // Hand-derived window sums: 0 ones*ones, 1 centre tap on ramp, 2 all 63, 3 ones on ramp.
    task automatic push_exp(input int mode, input int bp_idx);
        for (int idx = 0; idx < 16; idx++) begin
            exp_t x;
            x.row = idx / 4;
            x.col = idx % 4;
            case (mode)
                0: x.data = 9;
                1: x.data = (x.row + 1) * 6 + (x.col + 1);
                2: x.data = 35721;
                default: x.data = 54 * (x.row + 1) + 9 * (x.col + 1);
            endcase
            x.last = (idx == 15) ? 1 : 0;
            x.gap  = (idx == 0 || idx == bp_idx) ? 0 : 10;
            sb.push_back(x);
        end
    endtask

    task automatic set_vecs(input int wmode, input int pmode);
        for (int i = 0; i < 9; i++) begin
            case (wmode)
                0: w_vec[i] = 6'd1;
                1: w_vec[i] = (i == 4) ? 6'd1 : 6'd0;
                default: w_vec[i] = 6'd63;
            endcase
        end
        for (int i = 0; i < 36; i++) begin
            case (pmode)
                0: p_vec[i] = 6'd1;
                1: p_vec[i] = 6'(i);
                default: p_vec[i] = 6'd63;
            endcase
        end
    endtask

    // All stimulus tasks start and end just after a rising edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        chk("wgt_ready_before_start_sampled", int'(wgt_ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_to_wgt_ready", int'(wgt_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic send_wgts(input int gap);
        for (int i = 0; i < 9; i++) begin
            int t;
            bit got;
            t = 0;
            got = 0;
            wgt_valid = 1'b1;
            wgt_data  = w_vec[i];
            while (!got && t < 100) begin
                @(negedge clk);
                t++;
                if (wgt_ready) got = 1;
                @(posedge clk); #1;
            end
            if (!got) chk("wgt_beat_timeout", 0, 1);
            wgt_valid = 1'b0;
            if (gap != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send_pix(input int n, input int gap, input int start_beat);
        for (int i = 0; i < n; i++) begin
            int t;
            bit got;
            t = 0;
            got = 0;
            pix_valid = 1'b1;
            pix_data  = p_vec[i];
            start     = (i == start_beat);
            while (!got && t < 100) begin
                @(negedge clk);
                t++;
                if (pix_ready) got = 1;
                @(posedge clk); #1;
            end
            if (!got) chk("pix_beat_timeout", 0, 1);
            pix_valid = 1'b0;
            start     = 1'b0;
            if (gap != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_end(input int b2b);
        int t;
        bit seen;
        t = 0;
        seen = 0;
        while (!seen && t < 3000) begin
            @(negedge clk);
            t++;
            if (out_valid && out_ready && out_last) seen = 1;
        end
        if (!seen) chk("last_output_timeout", 0, 1);
        @(negedge clk);
        chk("done_after_last", int'(done), 1);
        @(posedge clk); #1;
        if (b2b == 0) begin
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
            chk("busy_back_to_idle", int'(busy), 0);
            chk("scoreboard_drained", sb.size(), 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        start     = 1'b1;
        wgt_valid = 1'b0;
        wgt_data  = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        out_ready = 1'b1;

        // Reset with start held high: reset must win.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wgt_ready", int'(wgt_ready), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_out_col", int'(out_col), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Uniform run with first-result latency check.
        set_vecs(0, 0);
        push_exp(0, -1);
        do_start();
        send_wgts(0);
        send_pix(36, 0, -1);
        repeat (9) @(negedge clk);
        chk("first_out_not_early", int'(out_valid), 0);
        @(negedge clk);
        chk("first_out_latency", int'(out_valid), 1);
        @(posedge clk); #1;
        wait_end(0);

        // Centre-tap run with start pulses during LOAD_P and EMIT.
        set_vecs(1, 1);
        push_exp(1, -1);
        base = out_cnt;
        do_start();
        send_wgts(0);
        send_pix(36, 0, 17);
        @(negedge clk);
        chk("pix_ready_drops_after_36", int'(pix_ready), 0);
        @(posedge clk); #1;
        fork
            begin
                int t2;
                t2 = 0;
                while ((out_cnt < base + 3 || !out_valid) && t2 < 2000) begin
                    @(negedge clk);
                    t2++;
                end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join_none
        wait_end(0);
        chk("centre_output_count", out_cnt - base, 16);

        // Gapped inputs plus a 20-cycle stall at output 5.
        set_vecs(0, 0);
        push_exp(0, 4);
        base = out_cnt;
        fork
            begin
                int t3;
                t3 = 0;
                while (out_cnt < base + 4 && t3 < 3000) begin
                    @(posedge clk);
                    t3++;
                end
                #1;
                out_ready = 1'b0;
                t3 = 0;
                while (!out_valid && t3 < 100) begin
                    @(negedge clk);
                    t3++;
                end
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        do_start();
        send_wgts(1);
        send_pix(36, 1, -1);
        wait_end(0);

        // Reset after 20 pixels of a stale all-63 load.
        set_vecs(2, 2);
        do_start();
        send_wgts(0);
        send_pix(20, 0, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_ready", int'(pix_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_rowcol", int'(out_row) + int'(out_col), 0);
        @(posedge clk); #1;

        // Fresh run after the abort, unaffected by stale buffers.
        set_vecs(0, 1);
        push_exp(3, -1);
        do_start();
        send_wgts(0);
        send_pix(36, 0, -1);
        wait_end(1);

        // Back-to-back start in the IDLE cycle after done; max-value run.
        set_vecs(2, 2);
        push_exp(2, -1);
        do_start();
        send_wgts(0);
        send_pix(36, 0, -1);
        wait_end(0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Controller and shared-MAC sequencer for the convolution layer. It loads a KxK kernel and an IMG_DIM x IMG_DIM image through streaming valid/ready ports into local buffers.
- It then walks every valid (stride 1, no padding) window position. For each window it runs one shared multiply-accumulate unit over the KxK taps and emits one result per window.
- It sits between the upstream pixel/weight source and the downstream consumer of the output feature map.

Parameters:
DATA_W, 6, width of unsigned pixel and weight values
IMG_DIM, 6, input image side length
K, 3, kernel side length (K <= IMG_DIM)
OUT_DIM, IMG_DIM-K+1 (derived localparam), output feature-map side length
ACC_W, 2*DATA_W+$clog2(K*K) (derived localparam), accumulator/result width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; synchronous, active-low
start  input  1  begin a new layer run (sampled only in IDLE)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the final output is accepted
wgt_valid  input  1  weight beat valid
wgt_ready  output  1  high only in LOAD_W
wgt_data  input  DATA_W  kernel weight, row-major
pix_valid  input  1  pixel beat valid
pix_ready  output  1  high only in LOAD_P
pix_data  input  DATA_W  image pixel, row-major
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  ACC_W  window sum of products
out_row  output  $clog2(OUT_DIM)  output row index
out_col  output  $clog2(OUT_DIM)  output column index
out_last  output  1  high with the final result (row=col=OUT_DIM-1)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - All counters, the accumulator and out_data are cleared.
  - busy, done, wgt_ready, pix_ready, out_valid, out_last, out_row and out_col are all 0.
  - Buffer contents are not cleared; every run rewrites them before use.
  - Reset mid-run aborts immediately with no further handshakes.
- Beat transfer: a beat transfers when valid && ready at a rising edge. Gaps in valid are allowed; indices advance only on transfer.
- FSM states: IDLE, LOAD_W, LOAD_P, MAC, EMIT, DONE.
  - IDLE: start=1 -> LOAD_W next cycle. start is ignored in every other state.
  - LOAD_W: accepts K*K weights into w[i] for i = 0..K*K-1. After the last transfer -> LOAD_P.
  - LOAD_P: accepts IMG_DIM*IMG_DIM pixels into p[r][c], row-major. After the last transfer -> MAC, with window (0,0), tap 0, accumulator cleared.
  - MAC: exactly K*K cycles, one tap per cycle. acc += p[wr+kr][wc+kc] * w[kr*K+kc], taps row-major. After tap K*K-1 -> EMIT.
  - EMIT:
    - out_valid=1 and out_data = final acc. out_row, out_col and out_last are stable until accepted.
    - On transfer, if the window is not last: advance col (wrapping to 0 and incrementing row at OUT_DIM-1), clear acc, -> MAC.
    - If the window is last -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Latency:
  - start to wgt_ready is 1 cycle.
  - The first out_valid asserts K*K cycles after the cycle the last pixel transfers.
  - With out_ready tied high, each output occupies K*K+1 cycles. For defaults, outputs are spaced 10 cycles apart and there are 16 outputs.
- Arithmetic:
  - Values are unsigned. Products are 2*DATA_W bits and accumulate in ACC_W bits.
  - ACC_W is sized so overflow is impossible: default maximum 9*63*63 = 35721 < 2^16.
- Backpressure: out_valid holds with stable data indefinitely while out_ready=0. No computation proceeds during the stall.
- Result ordering: results are emitted in raster order, (0,0), (0,1), ..., (OUT_DIM-1, OUT_DIM-1).
- Simultaneous start and rst_n=0: reset wins.
- Back-to-back runs: start asserted in the cycle after done (state IDLE) begins a new run.
- Output/ready exclusivity: wgt_ready, pix_ready and out_valid are never high in the same cycle.

Test Plan:
- Uniform run: reset, then start; 9 weights = 1 and 36 pixels = 1, valid held high, out_ready=1. Expect 16 outputs all = 9; out_last only on the 16th, at row=3/col=3; done pulses 1 cycle after that; busy returns to 0.
- Centre-tap kernel: weights 0,0,0,0,1,0,0,0,0 and pixels p[r][c] = r*6+c. Expect out(r,c) = (r+1)*6 + (c+1), i.e. first = 7, last = 28, in raster order.
- Max value: all weights and pixels = 63. Expect every out_data = 35721 with no wrap.
- Backpressure and gaps:
  - Toggle wgt_valid/pix_valid every other cycle; results must match the uniform case.
  - Hold out_ready=0 for 20 cycles at output 5; out_valid, out_data, out_row and out_col must stay stable; output 6 arrives 10 cycles after release.
- Reset mid-load: drop rst_n for 1 cycle after 20 pixels. All outputs must be 0 and the state IDLE. A fresh full run must then give correct results, unaffected by stale buffer contents.
- Start while busy: pulse start during LOAD_P and during EMIT. There must be no restart, the beat counts must be unchanged and the run must complete normally. Then start in the cycle after done: LOAD_W must be entered and wgt_ready=1 on the next cycle.
